// File: rtl/gpio_wiggle_gen.sv
// Parametrised GPIO pattern generator: toggle, walking-one, counter and optional LFSR bursts.
// Define GPIO_WIGGLE_GEN_LFSR_EN to build the Galois LFSR for mode 3; otherwise mode 3 acts as mode 2.
module gpio_wiggle_gen #(
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DIV_W = 24,
    parameter int unsigned      CNT_W = 16,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003
) (
    input  logic             osc,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] gpio_out,
    output logic             busy,
    output logic             step,
    output logic             done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_l;
    logic [DIV_W-1:0] div_l, div_cnt;
    logic [CNT_W-1:0] count_l, step_cnt;
    logic [WIDTH-1:0] pattern, seed, next_pat;
    logic             step_q;
    logic             launch, div_hit, last_step, advance;

    assign launch    = (state == ST_IDLE) && start && !stop;
    assign div_hit   = (state == ST_RUN) && (div_cnt == div_l);
    assign last_step = (count_l != '0) && (step_cnt == count_l - CNT_W'(1));
    // A stop landing on a divider hit suppresses the advance unless it is the final one.
    assign advance   = div_hit && (!stop || last_step);

    always_comb begin
        seed = '0;
        case (mode)
            2'd0: seed = {(WIDTH/2){2'b01}};
            2'd1: seed = WIDTH'(1);
`ifdef GPIO_WIGGLE_GEN_LFSR_EN
            2'd3: seed = '1;
`endif
            default: seed = '0;
        endcase
    end

    always_comb begin
        next_pat = pattern;
        case (mode_l)
            2'd0: next_pat = ~pattern;
            2'd1: next_pat = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
`ifdef GPIO_WIGGLE_GEN_LFSR_EN
            2'd3: next_pat = {pattern[WIDTH-2:0], 1'b0} ^ (pattern[WIDTH-1] ? TAPS : '0);
`endif
            default: next_pat = pattern + WIDTH'(1);
        endcase
    end

`ifndef GPIO_WIGGLE_GEN_LFSR_EN
    logic unused_taps;
    assign unused_taps = ^TAPS;
`endif

    always_ff @(posedge osc or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_RUN;
            ST_RUN:  if (stop || (advance && last_step)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            mode_l   <= '0;
            div_l    <= '0;
            count_l  <= '0;
            pattern  <= '0;
            div_cnt  <= '0;
            step_cnt <= '0;
            step_q   <= 1'b0;
        end else begin
            step_q <= advance;
            if (launch) begin
                mode_l   <= mode;
                div_l    <= div;
                count_l  <= count;
                pattern  <= seed;
                div_cnt  <= '0;
                step_cnt <= '0;
            end else if (state == ST_RUN) begin
                if (div_hit) div_cnt <= '0;
                else         div_cnt <= div_cnt + DIV_W'(1);
                if (advance) begin
                    pattern  <= next_pat;
                    step_cnt <= step_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        gpio_out = pattern;
        busy     = (state == ST_RUN);
        done     = (state == ST_DONE);
        step     = step_q;
    end

endmodule
